// File: rtl/uart_rx_frontend.sv
// uart_rx_frontend
//   Receive path of the SoC UART. Synchronizes the asynchronous rx line and
//   recovers frames of 1 start bit, 8 data bits (LSB first), an optional even
//   parity bit and 1 stop bit. Each decoded byte and its error flags are
//   buffered in a small FIFO, which is drained over a valid/ready stream.
//
// Ports
//   clk              system clock
//   nreset           asynchronous active-low reset
//   divisor          clock cycles per bit minus 1 (clamped to a minimum of 3)
//   rx               serial input, idles high
//   rsp_valid        FIFO head is valid
//   rsp_ready        consumer takes the head entry
//   rsp_data         received byte at the FIFO head
//   rsp_parity_error parity mismatch for the head byte
//   rsp_frame_error  stop bit was sampled low for the head byte
//   fifo_level       number of entries held in the FIFO
//   overflow         sticky: a byte was dropped because the FIFO was full
//   clear_overflow   single-cycle pulse clearing overflow
//   busy             receiver state machine is not idle
module uart_rx_frontend #(
  parameter int FIFO_DEPTH  = 8,
  parameter int SYNC_STAGES = 2,
  parameter int PARITY_EN   = 1
) (
  input  logic                            clk,
  input  logic                            nreset,
  input  logic [15:0]                     divisor,
  input  logic                            rx,
  output logic                            rsp_valid,
  input  logic                            rsp_ready,
  output logic [7:0]                      rsp_data,
  output logic                            rsp_parity_error,
  output logic                            rsp_frame_error,
  output logic [$clog2(FIFO_DEPTH+1)-1:0] fifo_level,
  output logic                            overflow,
  input  logic                            clear_overflow,
  output logic                            busy
);

  localparam int LVL_W = $clog2(FIFO_DEPTH + 1);
  localparam int PTR_W = $clog2(FIFO_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP,
    S_WAIT_IDLE
  } state_t;

  // ---------------------------------------------------------------------------
  // Input synchronizer; preset to 1 so a reset never looks like a start bit.
  // ---------------------------------------------------------------------------
  logic [SYNC_STAGES-1:0] sync_reg;
  logic                   rx_sync;

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      sync_reg <= '1;
    end else begin
      sync_reg[0] <= rx;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        sync_reg[i] <= sync_reg[i-1];
      end
    end
  end

  assign rx_sync = sync_reg[SYNC_STAGES-1];

  // ---------------------------------------------------------------------------
  // Frame state machine
  // ---------------------------------------------------------------------------
  state_t      state_reg;
  logic [16:0] cnt_reg;
  logic [16:0] period_reg;
  logic [2:0]  bit_idx_reg;
  logic [7:0]  shift_reg;
  logic        par_err_reg;

  // Bit period with very small divisors clamped so the half-bit count stays >= 1.
  logic [16:0] period_now;
  logic [16:0] half_now;

  assign period_now = (({1'b0, divisor} < 17'd3) ? 17'd3 : {1'b0, divisor}) + 17'd1;
  assign half_now   = (period_now >> 1) - 17'd1;

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state_reg   <= S_IDLE;
      cnt_reg     <= '0;
      period_reg  <= '0;
      bit_idx_reg <= '0;
      shift_reg   <= '0;
      par_err_reg <= 1'b0;
    end else begin
      case (state_reg)
        S_IDLE: begin
          if (!rx_sync) begin
            state_reg  <= S_START;
            period_reg <= period_now;
            cnt_reg    <= half_now;
          end
        end
        S_START: begin
          if (cnt_reg == '0) begin
            if (rx_sync) begin
              state_reg <= S_IDLE;  // glitch, not a real start bit
            end else begin
              state_reg   <= S_DATA;
              bit_idx_reg <= 3'd0;
              cnt_reg     <= period_reg - 17'd1;
            end
          end else begin
            cnt_reg <= cnt_reg - 17'd1;
          end
        end
        S_DATA: begin
          if (cnt_reg == '0) begin
            shift_reg[bit_idx_reg] <= rx_sync;
            cnt_reg                <= period_reg - 17'd1;
            if (bit_idx_reg == 3'd7) begin
              state_reg <= (PARITY_EN != 0) ? S_PARITY : S_STOP;
            end else begin
              bit_idx_reg <= bit_idx_reg + 3'd1;
            end
          end else begin
            cnt_reg <= cnt_reg - 17'd1;
          end
        end
        S_PARITY: begin
          if (cnt_reg == '0) begin
            par_err_reg <= rx_sync ^ (^shift_reg);
            cnt_reg     <= period_reg - 17'd1;
            state_reg   <= S_STOP;
          end else begin
            cnt_reg <= cnt_reg - 17'd1;
          end
        end
        S_STOP: begin
          if (cnt_reg == '0) begin
            // Leaving at mid-stop-bit allows back-to-back frames; a low stop bit
            // (break) parks in WAIT_IDLE so the held-low line yields one frame.
            state_reg <= rx_sync ? S_IDLE : S_WAIT_IDLE;
          end else begin
            cnt_reg <= cnt_reg - 17'd1;
          end
        end
        S_WAIT_IDLE: begin
          if (rx_sync) begin
            state_reg <= S_IDLE;
          end
        end
        default: state_reg <= S_IDLE;
      endcase
    end
  end

  assign busy = (state_reg != S_IDLE);

  // Frame completes on the stop-bit sample cycle.
  logic       push;
  logic [9:0] push_word;

  assign push      = (state_reg == S_STOP) && (cnt_reg == '0);
  assign push_word = {~rx_sync, (PARITY_EN != 0) && par_err_reg, shift_reg};

  // ---------------------------------------------------------------------------
  // Receive FIFO: {frame_error, parity_error, data}
  // ---------------------------------------------------------------------------
  logic [9:0]       mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_reg;
  logic [PTR_W-1:0] rd_ptr_reg;
  logic [LVL_W-1:0] level_reg;
  logic             overflow_reg;
  logic             full;
  logic             pop;
  logic             do_push;
  logic             drop;
  logic [9:0]       head;

  assign full    = (level_reg == LVL_W'(FIFO_DEPTH));
  assign pop     = rsp_valid && rsp_ready;
  // A pop frees the slot in the same cycle, so a full FIFO still accepts.
  assign do_push = push && (!full || pop);
  assign drop    = push && full && !pop;

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr_reg] <= push_word;
    end
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      level_reg    <= '0;
      overflow_reg <= 1'b0;
    end else begin
      if (do_push) begin
        wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
      end
      case ({do_push, pop})
        2'b10:   level_reg <= level_reg + LVL_W'(1);
        2'b01:   level_reg <= level_reg - LVL_W'(1);
        default: level_reg <= level_reg;
      endcase
      // A drop in the same cycle as a clear must leave the flag set.
      if (drop) begin
        overflow_reg <= 1'b1;
      end else if (clear_overflow) begin
        overflow_reg <= 1'b0;
      end
    end
  end

  // Head fields are forced to zero while empty so stale storage never shows.
  assign head             = mem[rd_ptr_reg];
  assign rsp_valid        = (level_reg != '0);
  assign rsp_data         = rsp_valid ? head[7:0] : 8'h00;
  assign rsp_parity_error = rsp_valid && head[8];
  assign rsp_frame_error  = rsp_valid && head[9];
  assign fifo_level       = level_reg;
  assign overflow         = overflow_reg;

endmodule

// File: doc/uart_rx_frontend.md
Name: uart_rx_frontend

Overview:
- Receive path of the SoC UART controller.
- Consumes the serial io_uart_rx line and recovers 8-bit frames: 1 start bit, 8 data bits LSB first, 1 even-parity bit (parity bit = XOR of the data bits), 1 stop bit.
- Decoded bytes and their error flags are buffered in a small FIFO.
- The FIFO is drained by the UART register block over a valid/ready stream.

Parameters:
- FIFO_DEPTH, 8, receive FIFO entries; must be a power of 2, minimum 2.
- SYNC_STAGES, 2, flip-flop synchronizer depth on rx.
- PARITY_EN, 1, 1 = a parity bit is expected and checked; 0 = frame has no parity bit.

Ports:
- clk  input  1  system clock.
- nreset  input  1  asynchronous, active-low reset.
- divisor  input  16  clock cycles per bit minus 1; the controller writes CPU_FREQ/BAUD-1.
- rx  input  1  serial line, asynchronous, idles high.
- rsp_valid  output  1  FIFO head valid.
- rsp_ready  input  1  consumer accepts the head entry.
- rsp_data  output  8  received byte.
- rsp_parity_error  output  1  parity mismatch for this byte.
- rsp_frame_error  output  1  stop bit sampled low for this byte.
- fifo_level  output  $clog2(FIFO_DEPTH+1)  current number of entries.
- overflow  output  1  sticky flag: a byte was dropped because the FIFO was full.
- clear_overflow  input  1  single-cycle pulse that clears overflow.
- busy  output  1  state machine is not in IDLE.

Behaviour:
- Reset: asynchronous on nreset low. All synchronizer flops are set to 1. FSM goes to IDLE, FIFO empties. rsp_valid, rsp_data, both error flags, fifo_level, overflow and busy all read 0.
- Reset mid-frame aborts the frame with no push.
- Synchronizer: the FSM sees rx through SYNC_STAGES flops, so an rx edge is visible SYNC_STAGES cycles after it occurs.
- Bit period: P = max(divisor, 3) + 1 cycles. divisor is latched on start-bit detection and is held constant for the whole frame.
- IDLE: synced rx == 0 → enter START, load counter = P/2 - 1 (integer division).
- START: decrement counter. At 0, sample rx:
  - rx == 1: false start, return to IDLE.
  - rx == 0: enter DATA, bit index = 0, counter = P-1.
- DATA: on each counter expiry, sample rx into shift register bit[index], reload counter = P-1. After index 7 is sampled, go to PARITY (PARITY_EN=1) or STOP (PARITY_EN=0).
- PARITY: sample at expiry; parity_error = sample XOR (XOR of data bits). Go to STOP.
- STOP: sample at expiry. The frame is pushed in the same cycle, with frame_error = ~sample.
  - sample == 1: return to IDLE immediately, at mid-stop-bit. This lets back-to-back frames with no idle gap be received.
  - sample == 0: go to WAIT_IDLE and stay there until synced rx == 1, then go to IDLE. A break condition therefore yields exactly one frame.
- FIFO: registered storage, not fall-through.
  - Pushed data is visible on rsp_* with rsp_valid = 1 on the cycle after the push, if the FIFO was empty.
  - A pop happens when rsp_valid && rsp_ready.
- FIFO boundary cases:
  - Push and pop in the same cycle while full: both are performed, level is unchanged, no overflow.
  - Push while full with no pop: the byte is dropped, FIFO contents are unchanged, overflow is set to 1 on the next cycle.
  - Push and pop at level 1: the new entry becomes the head, level stays 1.
  - Pointers wrap modulo FIFO_DEPTH.
- overflow: a push-drop and clear_overflow in the same cycle leave overflow = 1, because set wins.
- busy = (state != IDLE).

Test Plan:
1. divisor=5 (P=6), send 0xA5 with parity 0, stop 1, rsp_ready=1 → rsp_valid pulse with rsp_data=0xA5, parity_error=0, frame_error=0, fifo_level returns to 0.
2. divisor=5, send 0x01 with parity bit 0 (wrong) → rsp_data=0x01, rsp_parity_error=1. Then send 0x03 with parity 0 (correct) → parity_error=0.
3. divisor=5, send 0x55 with stop bit 0, then hold rx low for 40 cycles → exactly one entry with frame_error=1, busy stays high until rx returns high, no second entry.
4. rx low for 2 cycles, then high → no push, busy returns to 0 within P/2+SYNC_STAGES cycles.
5. rsp_ready=0, send 9 frames 0x10..0x18 → fifo_level=8, overflow=1, popped sequence 0x10..0x17. Pulse clear_overflow → overflow=0.
6. Assert nreset low during data bit 4 of a frame, then release → FIFO empty, no entry, the next valid frame 0x3C is received correctly.
